// File: rtl/clock_period_checker.sv
// Measures the rising-edge-to-rising-edge period of an asynchronous derived clock
// in reference-clock cycles, checks it against limits and reports it with sticky errors.
module clock_period_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             probe,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic [CNT_W-1:0] period_bits,
  output logic             err_short,
  output logic             err_long,
  output logic             err_overrun,
  input  logic             clear_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [CNT_W-1:0] cnt;

  logic rise;
  logic newMeas;
  logic minOn;
  logic maxOn;
  logic cntOverMax;
  logic shortHit;
  logic longHit;
  logic stallHit;
  logic overrunHit;

  // Count up by one, holding at all-ones so a stopped probe never wraps to a short period.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (&v) ? v : v + CNT_W'(1);
  endfunction

  // A new sticky value: any set this cycle wins over a simultaneous clear.
  function automatic logic stickyNext(input logic cur, input logic set, input logic clr);
    stickyNext = set | (cur & ~clr);
  endfunction

  assign rise       = s2 & ~s3;
  assign newMeas    = (state == MEASURE) && enable && rise;
  assign minOn      = (min_period != '0);
  assign maxOn      = (max_period != '0);
  assign cntOverMax = maxOn && (cnt > max_period);

  assign shortHit   = newMeas && minOn && (cnt < min_period);
  assign longHit    = newMeas && cntOverMax;
  assign stallHit   = (state == MEASURE) && enable && !rise && cntOverMax;
  assign overrunHit = newMeas && period_valid && !period_ready;

  // Probe synchronizer plus history flop for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= probe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Measurement FSM and period counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) state <= ARM;
        end
        ARM: begin
          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rise) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt <= satInc(cnt);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // One-entry report buffer; a new measurement always replaces the held one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_valid <= 1'b0;
      period_bits  <= '0;
    end else if (newMeas) begin
      period_valid <= 1'b1;
      period_bits  <= cnt;
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
    end
  end

  // Sticky error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_short   <= stickyNext(err_short, shortHit, clear_err);
      err_long    <= stickyNext(err_long, longHit | stallHit, clear_err);
      err_overrun <= stickyNext(err_overrun, overrunHit, clear_err);
    end
  end

endmodule

// File: tb/tb_clock_period_checker.sv
// Directed bench for clock_period_checker: periods, limits, overrun, saturation, reset/enable.
module tb_clock_period_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        probe = 1'b0;
  logic [15:0] min_period = '0;
  logic [15:0] max_period = '0;
  logic        period_valid;
  logic        period_ready = 1'b0;
  logic [15:0] period_bits;
  logic        err_short;
  logic        err_long;
  logic        err_overrun;
  logic        clear_err = 1'b0;

  logic [3:0]  minB = '0;
  logic [3:0]  maxB = '0;
  logic        validB;
  logic [3:0]  bitsB;
  logic        shortB;
  logic        longB;
  logic        overrunB;

  int total = 0;
  int bad = 0;

  clock_period_checker #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .probe(probe),
    .min_period(min_period), .max_period(max_period),
    .period_valid(period_valid), .period_ready(period_ready), .period_bits(period_bits),
    .err_short(err_short), .err_long(err_long), .err_overrun(err_overrun),
    .clear_err(clear_err)
  );

  clock_period_checker #(.CNT_W(4)) dutB (
    .clock(clock), .reset_n(reset_n), .enable(enable), .probe(probe),
    .min_period(minB), .max_period(maxB),
    .period_valid(validB), .period_ready(period_ready), .period_bits(bitsB),
    .err_short(shortB), .err_long(longB), .err_overrun(overrunB),
    .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    probe = 1'b0;
    enable = 1'b0;
    period_ready = 1'b0;
    clear_err = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    resetDut();
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", period_valid); end
    total++; if (period_bits !== 16'd0) begin bad++; $display("FAIL reset_bits got=%0d want=0", period_bits); end
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL reset_short got=%0d want=0", err_short); end
    total++; if (err_long !== 1'b0) begin bad++; $display("FAIL reset_long got=%0d want=0", err_long); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0d want=0", err_overrun); end
  endtask

  task automatic test_basic_period();
    int reps = 0;
    int wrong = 0;
    resetDut();
    min_period = 16'd0; max_period = 16'd0; minB = '0; maxB = '0;
    period_ready = 1'b1; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 50; i++) begin
      probe = (i < 50) && ((i % 10) < 5);
      cyc();
      if (period_valid) begin
        reps++;
        if (period_bits !== 16'd10) wrong++;
      end
    end
    total++; if (reps !== 4) begin bad++; $display("FAIL basic_report_count got=%0d want=4", reps); end
    total++; if (wrong !== 0) begin bad++; $display("FAIL basic_report_value wrong=%0d want=0", wrong); end
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL basic_short got=%0d want=0", err_short); end
    total++; if (err_long !== 1'b0) begin bad++; $display("FAIL basic_long got=%0d want=0", err_long); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%0d want=0", err_overrun); end
  endtask

  task automatic test_short_and_clear();
    int reps = 0;
    int wrong = 0;
    resetDut();
    min_period = 16'd8; max_period = 16'd12;
    period_ready = 1'b1; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 28; i++) begin
      probe = (i < 24) && ((i % 6) < 3);
      cyc();
      if (period_valid) begin
        reps++;
        if (period_bits !== 16'd6) wrong++;
      end
    end
    total++; if (reps !== 3) begin bad++; $display("FAIL short_report_count got=%0d want=3", reps); end
    total++; if (wrong !== 0) begin bad++; $display("FAIL short_report_value wrong=%0d want=0", wrong); end
    total++; if (err_short !== 1'b1) begin bad++; $display("FAIL short_flag got=%0d want=1", err_short); end
    total++; if (err_long !== 1'b0) begin bad++; $display("FAIL short_long_flag got=%0d want=0", err_long); end
    enable = 1'b0;
    cyc();
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL short_clear got=%0d want=0", err_short); end
    min_period = 16'd0; max_period = 16'd0;
  endtask

  task automatic test_stall();
    int firstLong = -1;
    int reps = 0;
    int lastBits = -1;
    resetDut();
    min_period = 16'd0; max_period = 16'd20;
    period_ready = 1'b1; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 45; i++) begin
      probe = (i < 20) && ((i % 10) < 5);
      cyc();
      if (err_long && firstLong < 0) firstLong = i;
      if (period_valid) begin
        reps++;
        lastBits = int'(period_bits);
      end
    end
    total++; if (firstLong !== 33) begin bad++; $display("FAIL stall_long_cycle got=%0d want=33", firstLong); end
    total++; if (reps !== 1) begin bad++; $display("FAIL stall_report_count got=%0d want=1", reps); end
    total++; if (lastBits !== 10) begin bad++; $display("FAIL stall_report_value got=%0d want=10", lastBits); end
    enable = 1'b0;
    max_period = 16'd0;
  endtask

  task automatic test_overrun();
    resetDut();
    min_period = 16'd0; max_period = 16'd0;
    period_ready = 1'b0; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 16; i++) begin
      probe = (i % 4) < 2;
      clear_err = (i == 12);
      period_ready = (i >= 14);
      cyc();
      if (i == 11) begin
        total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0d want=1", period_valid); end
        total++; if (period_bits !== 16'd4) begin bad++; $display("FAIL ovr_bits got=%0d want=4", period_bits); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0d want=1", err_overrun); end
      end
      if (i == 12) begin
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0d want=0", err_overrun); end
      end
      if (i == 14) begin
        total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL ovr_b2b_valid got=%0d want=1", period_valid); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_b2b_flag got=%0d want=0", err_overrun); end
        total++; if (period_bits !== 16'd4) begin bad++; $display("FAIL ovr_b2b_bits got=%0d want=4", period_bits); end
      end
      if (i == 15) begin
        total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume got=%0d want=0", period_valid); end
      end
    end
    clear_err = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    int repsB = 0;
    int bitsSeenB = -1;
    int bitsSeenA = -1;
    resetDut();
    min_period = 16'd0; max_period = 16'd0; minB = '0; maxB = '0;
    period_ready = 1'b1; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 85; i++) begin
      probe = (i < 80) && ((i % 40) < 20);
      cyc();
      if (validB) begin
        repsB++;
        bitsSeenB = int'(bitsB);
      end
      if (period_valid) bitsSeenA = int'(period_bits);
    end
    total++; if (repsB !== 1) begin bad++; $display("FAIL sat_report_count got=%0d want=1", repsB); end
    total++; if (bitsSeenB !== 15) begin bad++; $display("FAIL sat_bits got=%0d want=15", bitsSeenB); end
    total++; if (bitsSeenA !== 40) begin bad++; $display("FAIL sat_wide_bits got=%0d want=40", bitsSeenA); end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    int firstV = -1;
    int firstBits = -1;
    resetDut();
    min_period = 16'd20; max_period = 16'd0;
    period_ready = 1'b0; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 16; i++) begin
      probe = (i % 10) < 5;
      cyc();
    end
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0d want=1", period_valid); end
    total++; if (err_short !== 1'b1) begin bad++; $display("FAIL rst_pre_short got=%0d want=1", err_short); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0d want=0", period_valid); end
    total++; if (period_bits !== 16'd0) begin bad++; $display("FAIL rst_async_bits got=%0d want=0", period_bits); end
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL rst_async_short got=%0d want=0", err_short); end
    total++; if (err_long !== 1'b0) begin bad++; $display("FAIL rst_async_long got=%0d want=0", err_long); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL rst_async_overrun got=%0d want=0", err_overrun); end
    probe = 1'b0;
    min_period = 16'd0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    for (int i = 0; i < 25; i++) begin
      probe = (i % 10) < 5;
      cyc();
      if (period_valid && firstV < 0) begin
        firstV = i;
        firstBits = int'(period_bits);
      end
    end
    total++; if (firstV !== 12) begin bad++; $display("FAIL rst_rearm_cycle got=%0d want=12", firstV); end
    total++; if (firstBits !== 10) begin bad++; $display("FAIL rst_rearm_bits got=%0d want=10", firstBits); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int firstV = -1;
    int firstBits = -1;
    resetDut();
    min_period = 16'd0; max_period = 16'd0;
    period_ready = 1'b1; enable = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 26; i++) begin
      probe = (i % 10) < 5;
      enable = !(i == 6 || i == 7);
      cyc();
      if (period_valid && firstV < 0) begin
        firstV = i;
        firstBits = int'(period_bits);
      end
    end
    total++; if (firstV !== 22) begin bad++; $display("FAIL en_first_report got=%0d want=22", firstV); end
    total++; if (firstBits !== 10) begin bad++; $display("FAIL en_first_bits got=%0d want=10", firstBits); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_short_and_clear();
    test_stall();
    test_overrun();
    test_saturation();
    test_async_reset();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
